// File: rtl/chip8_bcd_store_if.sv
`default_nettype none
// ============================================================================
// Module      : chip8_bcd_store_if
// Description : Memory write port used by the FX33 BCD store stage. The
//               master drives a write request with address and data; the
//               slave (memory) accepts it by raising mem_ack.
// Revision    : 1.0 - initial release
// ============================================================================
interface chip8_bcd_store_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack
    );
endinterface
`default_nettype wire

// File: rtl/chip8_bcd_store.sv
`default_nettype none
// ============================================================================
// Module      : chip8_bcd_store
// Description : Chip-8 FX33 store stage. Latches the I register and the three
//               BCD digits on start, then writes them as bytes to I, I+1 and
//               I+2 over a we/ack memory port and pulses done.
//               Build option CHIP8_BCD_ADDR_WRAP_EN: when defined, addresses
//               wrap modulo 2^ADDR_W and err is tied low; otherwise writes
//               whose address overflows are skipped and err pulses with done.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_bcd_store #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  wire                clk,
    input  wire                reset,
    input  wire                start,
    input  wire [ADDR_W-1:0]   index_reg,
    input  wire [3:0]          hundreds,
    input  wire [3:0]          tens,
    input  wire [3:0]          ones,
    chip8_bcd_store_if.master  mem,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR_H = 3'd1;
    localparam logic [2:0] S_WR_T = 3'd2;
    localparam logic [2:0] S_WR_O = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [3:0]        hund_q,  hund_d;
    logic [3:0]        tens_q,  tens_d;
    logic [3:0]        ones_q,  ones_d;

    logic [1:0]        offset;
    logic [3:0]        digit;
    logic              in_wr;
    logic              we;
`ifdef CHIP8_BCD_ADDR_WRAP_EN
    logic [ADDR_W-1:0] addr_sum;
`else
    logic [ADDR_W:0]   addr_sum;
    logic              skip_q, skip_d;
`endif

    // Select the byte offset and digit for the current write state and form the address
    always_comb begin
        offset = 2'd0;
        digit  = 4'd0;
        in_wr  = 1'b0;
        case (state_q)
            S_WR_H: begin in_wr = 1'b1; offset = 2'd0; digit = hund_q; end
            S_WR_T: begin in_wr = 1'b1; offset = 2'd1; digit = tens_q; end
            S_WR_O: begin in_wr = 1'b1; offset = 2'd2; digit = ones_q; end
            default: ;
        endcase
`ifdef CHIP8_BCD_ADDR_WRAP_EN
        // Plain ADDR_W-bit sum wraps naturally past the top of memory
        addr_sum = base_q + {{(ADDR_W-2){1'b0}}, offset};
        we       = in_wr;
`else
        // The extra top bit flags an address beyond the memory; that write is dropped
        addr_sum = {1'b0, base_q} + {{(ADDR_W-1){1'b0}}, offset};
        we       = in_wr & ~addr_sum[ADDR_W];
`endif
    end

    // Drive the memory port and status outputs; addr/data read as zero when not writing
    always_comb begin
        mem.mem_we    = we;
        mem.mem_addr  = we ? addr_sum[ADDR_W-1:0] : '0;
        mem.mem_wdata = we ? {{(DATA_W-4){1'b0}}, digit} : '0;
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
`ifdef CHIP8_BCD_ADDR_WRAP_EN
        err           = 1'b0;
`else
        err           = (state_q == S_DONE) & skip_q;
`endif
    end

    // Next-state logic: latch operands on start, step through the writes on ack
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
`ifndef CHIP8_BCD_ADDR_WRAP_EN
        skip_d  = skip_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WR_H;
                    base_d  = index_reg;
                    hund_d  = hundreds;
                    tens_d  = tens;
                    ones_d  = ones;
`ifndef CHIP8_BCD_ADDR_WRAP_EN
                    skip_d  = 1'b0;
`endif
                end
            end
            // A skipped write (we low) lasts exactly one cycle
            S_WR_H: if (!we || mem.mem_ack) state_d = S_WR_T;
            S_WR_T: if (!we || mem.mem_ack) state_d = S_WR_O;
            S_WR_O: if (!we || mem.mem_ack) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifndef CHIP8_BCD_ADDR_WRAP_EN
        if (in_wr && !we) skip_d = 1'b1;
`endif
    end

    // State and operand registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
`ifndef CHIP8_BCD_ADDR_WRAP_EN
            skip_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
`ifndef CHIP8_BCD_ADDR_WRAP_EN
            skip_q  <= skip_d;
`endif
        end
    end

endmodule
`default_nettype wire
